// File: rtl/sf_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter for the write port of a store-and-forward FIFO.
// Oversized packets are cut with an error-EOP (FIFO rolls back) and the remainder drained.
module sf_fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LG2   = 4,
    parameter int MAX_PKT_LEN = (1 << DEPTH_LG2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_eop_i,
    input  logic [NUM_REQ-1:0]            req_error_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wren_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic                          fifo_eop_o,
    output logic                          fifo_error_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              err_sticky;

    logic              owner_valid;
    logic              owner_eop;
    logic              owner_err;
    logic              last_beat;
    logic              accept;
    logic              drop_accept;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;

    assign owner_valid  = req_valid_i[owner];
    assign owner_eop    = req_eop_i[owner];
    assign owner_err    = req_error_i[owner];
    assign fifo_wdata_o = req_data_i[owner*DATA_WIDTH +: DATA_WIDTH];
    assign last_beat    = (beat_cnt == CNT_W'(MAX_PKT_LEN - 1));
    assign accept       = !rst && (state == XFER) && owner_valid && !fifo_full_i;
    assign drop_accept  = (state == DROP) && owner_valid;
    assign next_ptr     = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned cand;
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!sel_found && req_valid_i[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        fifo_wren_o  = 1'b0;
        fifo_eop_o   = 1'b0;
        fifo_error_o = 1'b0;
        if (!rst) begin
            case (state)
                XFER: begin
                    req_ready_o[owner] = !fifo_full_i;
                    fifo_wren_o        = accept;
                    if (accept) begin
                        // A real EOP on the last legal beat commits normally; only a missing EOP truncates.
                        fifo_eop_o   = owner_eop | last_beat;
                        fifo_error_o = owner_eop ? (owner_err | err_sticky) : last_beat;
                    end
                end
                DROP:    req_ready_o[owner] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            grant_o    <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            err_sticky <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner            <= sel_idx;
                        grant_o          <= '0;
                        grant_o[sel_idx] <= 1'b1;
                        state            <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        if (owner_eop) begin
                            beat_cnt   <= '0;
                            err_sticky <= 1'b0;
                            rr_ptr     <= next_ptr;
                            grant_o    <= '0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt   <= beat_cnt + 1'b1;
                            err_sticky <= err_sticky | owner_err;
                            if (last_beat) begin
                                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
                                state <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    if (drop_accept && owner_eop) begin
                        beat_cnt   <= '0;
                        err_sticky <= 1'b0;
                        rr_ptr     <= next_ptr;
                        grant_o    <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sf_fifo_wr_arbiter.sv
// Directed bench for sf_fifo_wr_arbiter: per-cycle vector table plus truncation/full-length/reset sequences.
module tb_sf_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]  req_eop_i;
    logic [NR-1:0]  req_error_i;
    logic [NR-1:0]  req_ready_o;
    logic           fifo_full_i;
    logic           fifo_wren_o;
    logic [DW-1:0]  fifo_wdata_o;
    logic           fifo_eop_o;
    logic           fifo_error_o;
    logic [NR-1:0]  grant_o;
    logic [15:0]    drop_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sf_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_LG2(4), .MAX_PKT_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_eop_i(req_eop_i), .req_error_i(req_error_i), .req_ready_o(req_ready_o),
        .fifo_full_i(fifo_full_i), .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o),
        .fifo_eop_o(fifo_eop_o), .fifo_error_o(fifo_error_o),
        .grant_o(grant_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v, e, er;
        logic        full;
        logic [3:0]  rdy;
        logic        wr, eop, err;
        logic [3:0]  gnt;
        logic [15:0] drop;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DW-1:0] beat_data(int k, int c);
        return {4'(k), 12'hABC, 16'(c)};
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance to just after the next posedge.
    task automatic step(string nm, logic r, logic [3:0] v, logic [3:0] e, logic [3:0] er, logic full,
                        logic [3:0] rdy, logic wr, logic eop, logic err, logic [3:0] gnt, logic [15:0] drop);
        int own;
        rst = r; req_valid_i = v; req_eop_i = e; req_error_i = er; fifo_full_i = full;
        for (int k = 0; k < NR; k++) req_data_i[k*DW +: DW] = beat_data(k, cyc);
        #3;
        cmp({nm, ".ready"}, 32'(req_ready_o), 32'(rdy));
        cmp({nm, ".wren"},  32'(fifo_wren_o), 32'(wr));
        cmp({nm, ".eop"},   32'(fifo_eop_o),  32'(eop));
        cmp({nm, ".error"}, 32'(fifo_error_o), 32'(err));
        cmp({nm, ".grant"}, 32'(grant_o),     32'(gnt));
        cmp({nm, ".drop"},  32'(drop_cnt_o),  32'(drop));
        if (wr) begin
            own = 0;
            for (int k = 0; k < NR; k++) if (gnt[k]) own = k;
            cmp({nm, ".wdata"}, fifo_wdata_o, beat_data(own, cyc));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; req_valid_i = '0; req_eop_i = '0; req_error_i = '0; fifo_full_i = 1'b0; req_data_i = '0;
        repeat (2) @(posedge clk);
        #1;

        //                 rst v     e     er   full  rdy  wr eop err gnt  drop
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        tbl.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        for (int p = 0; p < 4; p++) begin
            logic [3:0] g;
            g = 4'(1 << p);
            tbl.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 0, g, 1, 0, 0, g, 16'd0});
            tbl.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 0, g, 1, 0, 0, g, 16'd0});
            tbl.push_back(vec_t'{0, 4'hF, 4'hF, 4'h0, 0, g, 1, 1, 0, g, 16'd0});
            tbl.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        end
        // wrap back to requester 0 with a single-beat packet
        tbl.push_back(vec_t'{0, 4'hF, 4'hF, 4'h0, 0, 4'h1, 1, 1, 0, 4'h1, 16'd0});
        tbl.push_back(vec_t'{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        // requester 2: error on beat 2, clean EOP -> error on EOP; next packet clean
        tbl.push_back(vec_t'{0, 4'h4, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h0, 4'h0, 0, 4'h4, 1, 0, 0, 4'h4, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h0, 4'h4, 0, 4'h4, 1, 0, 0, 4'h4, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h0, 4'h0, 0, 4'h4, 1, 0, 0, 4'h4, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 1, 1, 4'h4, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        tbl.push_back(vec_t'{0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 1, 0, 4'h4, 16'd0});
        tbl.push_back(vec_t'{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        // requester 1: 5 beats with 4 full cycles after beat 1
        tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 0, 4'h2, 1, 0, 0, 4'h2, 16'd0});
        for (int i = 0; i < 4; i++)
            tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h2, 16'd0});
        for (int i = 0; i < 3; i++)
            tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 0, 4'h2, 1, 0, 0, 4'h2, 16'd0});
        tbl.push_back(vec_t'{0, 4'h2, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h2, 16'd0});
        // owner drops valid mid-packet; non-owner requests ignored
        tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});
        tbl.push_back(vec_t'{0, 4'h2, 4'h0, 4'h0, 0, 4'h2, 1, 0, 0, 4'h2, 16'd0});
        tbl.push_back(vec_t'{0, 4'hD, 4'h0, 4'h0, 0, 4'h2, 0, 0, 0, 4'h2, 16'd0});
        tbl.push_back(vec_t'{0, 4'h2, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h2, 16'd0});
        tbl.push_back(vec_t'{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0});

        foreach (tbl[i])
            step($sformatf("vec[%0d]", i), tbl[i].rst, tbl[i].v, tbl[i].e, tbl[i].er, tbl[i].full,
                 tbl[i].rdy, tbl[i].wr, tbl[i].eop, tbl[i].err, tbl[i].gnt, tbl[i].drop);

        // 20-beat packet from requester 0: beat 16 truncated, 17..20 drained
        step("trunc.idle", 0, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0);
        for (int b = 1; b <= 20; b++) begin
            if (b <= 16)
                step($sformatf("trunc.b%0d", b), 0, 4'h1, 4'h0, 4'h0, 0,
                     4'h1, 1, b == 16, b == 16, 4'h1, 16'd0);
            else
                step($sformatf("trunc.b%0d", b), 0, 4'h1, (b == 20) ? 4'h1 : 4'h0, 4'h0, b == 18,
                     4'h1, 0, 0, 0, 4'h1, 16'd1);
        end
        step("trunc.next", 0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd1);
        step("trunc.req1", 0, 4'hF, 4'hF, 4'h0, 0, 4'h2, 1, 1, 0, 4'h2, 16'd1);

        // exactly 16 beats from requester 2: committed cleanly
        step("full16.idle", 0, 4'h4, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd1);
        for (int b = 1; b <= 16; b++)
            step($sformatf("full16.b%0d", b), 0, 4'h4, (b == 16) ? 4'h4 : 4'h0, 4'h0, 0,
                 4'h4, 1, b == 16, 0, 4'h4, 16'd1);

        // reset on beat 3 of requester 3; arbitration restarts at requester 0
        step("rst.idle", 0, 4'h8, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd1);
        step("rst.b1",   0, 4'h8, 4'h0, 4'h0, 0, 4'h8, 1, 0, 0, 4'h8, 16'd1);
        step("rst.b2",   0, 4'h8, 4'h0, 4'h0, 0, 4'h8, 1, 0, 0, 4'h8, 16'd1);
        step("rst.b3",   1, 4'h8, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h8, 16'd1);
        step("rst.after", 0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 16'd0);
        step("rst.grant", 0, 4'hF, 4'hF, 4'h0, 0, 4'h1, 1, 1, 0, 4'h1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
